// File: rtl/reorder_buffer.sv
// In-order commit buffer: hands out rename tags, captures CDB results and retires
// one entry per cycle to the regfile or LSB, redirecting fetch on a mispredicted branch.
module reorder_buffer #(
    parameter int ROB_WIDTH  = 4,
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  dispatcher_rob_en_in,
    input  logic [1:0]            dispatcher_rob_type_in,
    input  logic [REG_WIDTH-1:0]  dispatcher_rob_dest_in,
    output logic [ROB_WIDTH-1:0]  rob_dispatcher_tag_out,
    output logic                  rob_dispatcher_full_out,
    input  logic [ROB_WIDTH-1:0]  dispatcher_rob_rs_h_in,
    input  logic [ROB_WIDTH-1:0]  dispatcher_rob_rt_h_in,
    output logic                  rob_dispatcher_rs_ready_out,
    output logic                  rob_dispatcher_rt_ready_out,
    output logic [DATA_WIDTH-1:0] rob_dispatcher_rs_value_out,
    output logic [DATA_WIDTH-1:0] rob_dispatcher_rt_value_out,
    input  logic                  cdb_rob_en_in,
    input  logic [ROB_WIDTH-1:0]  cdb_rob_h_in,
    input  logic [DATA_WIDTH-1:0] cdb_rob_value_in,
    input  logic                  cdb_rob_mispredict_in,
    input  logic [DATA_WIDTH-1:0] cdb_rob_target_in,
    input  logic                  lsb_rob_ready_in,
    output logic                  rob_regfile_en_out,
    output logic [REG_WIDTH-1:0]  rob_regfile_d_out,
    output logic [DATA_WIDTH-1:0] rob_regfile_value_out,
    output logic [ROB_WIDTH-1:0]  rob_regfile_h_out,
    output logic                  rob_regfile_rst_out,
    output logic                  rob_lsb_commit_out,
    output logic [ROB_WIDTH-1:0]  rob_lsb_h_out,
    output logic                  rob_fetcher_rst_out,
    output logic [DATA_WIDTH-1:0] rob_fetcher_pc_out
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] FIRST = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH-1:0] LAST  = '1;
    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t                           state;
    logic [ROB_WIDTH-1:0]             head, tail, count;
    logic [DATA_WIDTH-1:0]            flush_pc;
    logic [DEPTH-1:0]                 ent_valid, ent_ready, ent_mp;
    logic [DEPTH-1:0][1:0]            ent_type;
    logic [DEPTH-1:0][REG_WIDTH-1:0]  ent_dest;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_value, ent_target;

    logic alloc, commit;
    logic [DATA_WIDTH:0] rs_q, rt_q;

    // Slot 0 is the reserved "no tag", so pointers wrap from the last slot to 1.
    function automatic logic [ROB_WIDTH-1:0] wrap_inc(input logic [ROB_WIDTH-1:0] i);
        return (i == LAST) ? FIRST : i + 1'b1;
    endfunction

    function automatic logic [DATA_WIDTH:0] query(input logic [ROB_WIDTH-1:0] h);
        if (h == '0)
            return '0;
        if (cdb_rob_en_in && cdb_rob_h_in == h)
            return {1'b1, cdb_rob_value_in};
        if (ent_valid[h] && ent_ready[h])
            return {1'b1, ent_value[h]};
        return '0;
    endfunction

    assign rob_dispatcher_tag_out  = tail;
    assign rob_dispatcher_full_out = (count == LAST) || (state == ST_FLUSH);

    assign alloc  = dispatcher_rob_en_in && !rob_dispatcher_full_out;
    assign commit = (state == ST_RUN) && ent_valid[head] && ent_ready[head] &&
                    (ent_type[head] != TYPE_STORE || lsb_rob_ready_in);

    always_comb begin
        rs_q = query(dispatcher_rob_rs_h_in);
        rt_q = query(dispatcher_rob_rt_h_in);
    end

    assign rob_dispatcher_rs_ready_out = rs_q[DATA_WIDTH];
    assign rob_dispatcher_rs_value_out = rs_q[DATA_WIDTH-1:0];
    assign rob_dispatcher_rt_ready_out = rt_q[DATA_WIDTH];
    assign rob_dispatcher_rt_value_out = rt_q[DATA_WIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                 <= ST_RUN;
            head                  <= FIRST;
            tail                  <= FIRST;
            count                 <= '0;
            flush_pc              <= '0;
            ent_valid             <= '0;
            ent_ready             <= '0;
            ent_mp                <= '0;
            rob_regfile_en_out    <= 1'b0;
            rob_regfile_d_out     <= '0;
            rob_regfile_value_out <= '0;
            rob_regfile_h_out     <= '0;
            rob_regfile_rst_out   <= 1'b0;
            rob_lsb_commit_out    <= 1'b0;
            rob_lsb_h_out         <= '0;
            rob_fetcher_rst_out   <= 1'b0;
            rob_fetcher_pc_out    <= '0;
        end else if (rdy_in) begin
            rob_regfile_en_out  <= 1'b0;
            rob_regfile_rst_out <= 1'b0;
            rob_lsb_commit_out  <= 1'b0;
            rob_fetcher_rst_out <= 1'b0;
            if (state == ST_FLUSH) begin
                // Link write went out last cycle; now drop all speculative state.
                rob_regfile_rst_out <= 1'b1;
                rob_fetcher_rst_out <= 1'b1;
                rob_fetcher_pc_out  <= flush_pc;
                ent_valid           <= '0;
                head                <= FIRST;
                tail                <= FIRST;
                count               <= '0;
                state               <= ST_RUN;
            end else begin
                if (cdb_rob_en_in && ent_valid[cdb_rob_h_in]) begin
                    ent_ready[cdb_rob_h_in]  <= 1'b1;
                    ent_value[cdb_rob_h_in]  <= cdb_rob_value_in;
                    ent_mp[cdb_rob_h_in]     <= cdb_rob_mispredict_in &&
                                                ent_type[cdb_rob_h_in] == TYPE_BRANCH;
                    ent_target[cdb_rob_h_in] <= cdb_rob_target_in;
                end
                if (alloc) begin
                    ent_valid[tail] <= 1'b1;
                    ent_ready[tail] <= 1'b0;
                    ent_mp[tail]    <= 1'b0;
                    ent_type[tail]  <= dispatcher_rob_type_in;
                    ent_dest[tail]  <= dispatcher_rob_dest_in;
                    tail            <= wrap_inc(tail);
                end
                if (commit) begin
                    ent_valid[head] <= 1'b0;
                    head            <= wrap_inc(head);
                    if (ent_type[head] == TYPE_STORE) begin
                        rob_lsb_commit_out <= 1'b1;
                        rob_lsb_h_out      <= head;
                    end else begin
                        rob_regfile_en_out    <= (ent_dest[head] != '0);
                        rob_regfile_d_out     <= ent_dest[head];
                        rob_regfile_value_out <= ent_value[head];
                        rob_regfile_h_out     <= head;
                        if (ent_mp[head]) begin
                            flush_pc <= ent_target[head];
                            state    <= ST_FLUSH;
                        end
                    end
                end
                if (alloc && !commit)
                    count <= count + 1'b1;
                else if (!alloc && commit)
                    count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus a randomized run checked
// against a queue-based model of the commit buffer.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, en, cdb_en, cdb_mp, lsb_rdy;
    logic [1:0]  typ;
    logic [4:0]  dest;
    logic [3:0]  rs_h, rt_h, cdb_h;
    logic [31:0] cdb_val, cdb_tgt;
    logic [3:0]  tag, rf_h, lsb_h;
    logic        full, rs_rdy, rt_rdy, rf_en, rf_rst, lsb_c, f_rst;
    logic [31:0] rs_val, rt_val, rf_val, f_pc;
    logic [4:0]  rf_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .dispatcher_rob_en_in(en), .dispatcher_rob_type_in(typ), .dispatcher_rob_dest_in(dest),
        .rob_dispatcher_tag_out(tag), .rob_dispatcher_full_out(full),
        .dispatcher_rob_rs_h_in(rs_h), .dispatcher_rob_rt_h_in(rt_h),
        .rob_dispatcher_rs_ready_out(rs_rdy), .rob_dispatcher_rt_ready_out(rt_rdy),
        .rob_dispatcher_rs_value_out(rs_val), .rob_dispatcher_rt_value_out(rt_val),
        .cdb_rob_en_in(cdb_en), .cdb_rob_h_in(cdb_h), .cdb_rob_value_in(cdb_val),
        .cdb_rob_mispredict_in(cdb_mp), .cdb_rob_target_in(cdb_tgt),
        .lsb_rob_ready_in(lsb_rdy),
        .rob_regfile_en_out(rf_en), .rob_regfile_d_out(rf_d), .rob_regfile_value_out(rf_val),
        .rob_regfile_h_out(rf_h), .rob_regfile_rst_out(rf_rst),
        .rob_lsb_commit_out(lsb_c), .rob_lsb_h_out(lsb_h),
        .rob_fetcher_rst_out(f_rst), .rob_fetcher_pc_out(f_pc)
    );

    // Reference model: program-ordered queue of in-flight instructions.
    typedef struct {
        logic [3:0]  tag;
        logic [1:0]  typ;
        logic [4:0]  dest;
        bit          rdy;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_next = 4'd1;
    bit          m_flush = 0;
    logic [31:0] m_fpc = '0;
    logic        e_rf_en = 0, e_rf_rst = 0, e_lsb_c = 0, e_f_rst = 0;
    logic [4:0]  e_rf_d = '0;
    logic [31:0] e_rf_val = '0, e_f_pc = '0;
    logic [3:0]  e_rf_h = '0, e_lsb_h = '0;

    task automatic model_step();
        bit   full_now, do_commit;
        ent_t h;
        ent_t n;
        if (rst) begin
            q.delete(); m_next = 4'd1; m_flush = 0; m_fpc = '0;
            e_rf_en = 0; e_rf_rst = 0; e_lsb_c = 0; e_f_rst = 0;
            e_rf_d = '0; e_rf_val = '0; e_f_pc = '0; e_rf_h = '0; e_lsb_h = '0;
            return;
        end
        if (!rdy) return;
        e_rf_en = 0; e_rf_rst = 0; e_lsb_c = 0; e_f_rst = 0;
        if (m_flush) begin
            e_rf_rst = 1; e_f_rst = 1; e_f_pc = m_fpc;
            q.delete(); m_next = 4'd1; m_flush = 0;
            return;
        end
        full_now  = (q.size() == 15);
        do_commit = q.size() > 0 && q[0].rdy && (q[0].typ != 2'd2 || lsb_rdy);
        if (cdb_en)
            foreach (q[i])
                if (q[i].tag == cdb_h) begin
                    q[i].rdy = 1; q[i].val = cdb_val; q[i].tgt = cdb_tgt;
                    q[i].mp  = cdb_mp && q[i].typ == 2'd1;
                end
        if (do_commit) begin
            h = q.pop_front();
            if (h.typ == 2'd2) begin
                e_lsb_c = 1; e_lsb_h = h.tag;
            end else begin
                e_rf_en = (h.dest != 0); e_rf_d = h.dest; e_rf_val = h.val; e_rf_h = h.tag;
                if (h.mp) begin m_flush = 1; m_fpc = h.tgt; end
            end
        end
        if (en && !full_now) begin
            n.tag = m_next; n.typ = typ; n.dest = dest; n.rdy = 0; n.val = '0; n.mp = 0; n.tgt = '0;
            q.push_back(n);
            m_next = (m_next == 4'd15) ? 4'd1 : m_next + 4'd1;
        end
    endtask

    function automatic void m_query(input logic [3:0] h, output bit r, output logic [31:0] v);
        r = 0; v = '0;
        if (h == 0) return;
        if (cdb_en && cdb_h == h) begin r = 1; v = cdb_val; return; end
        foreach (q[i]) if (q[i].tag == h && q[i].rdy) begin r = 1; v = q[i].val; end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rdy = 1; en = 0; typ = 0; dest = 0; cdb_en = 0; cdb_h = 0; cdb_val = 0;
        cdb_mp = 0; cdb_tgt = 0; lsb_rdy = 0; rs_h = 0; rt_h = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; cyc(); rst = 0;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] d);
        en = 1; typ = t; dest = d; cyc(); en = 0;
    endtask

    task automatic bcast(input logic [3:0] h, input logic [31:0] v, input logic mp, input logic [31:0] tg);
        cdb_en = 1; cdb_h = h; cdb_val = v; cdb_mp = mp; cdb_tgt = tg; cyc(); cdb_en = 0; cdb_mp = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; cyc(); cyc(); rst = 0;
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL reset_rf_en: got %0h want 0", rf_en); end
        checks++; if (rf_d !== 5'd0) begin errors++; $display("FAIL reset_rf_d: got %0h want 0", rf_d); end
        checks++; if (rf_val !== 32'd0) begin errors++; $display("FAIL reset_rf_val: got %0h want 0", rf_val); end
        checks++; if (rf_h !== 4'd0) begin errors++; $display("FAIL reset_rf_h: got %0h want 0", rf_h); end
        checks++; if (rf_rst !== 1'b0) begin errors++; $display("FAIL reset_rf_rst: got %0h want 0", rf_rst); end
        checks++; if (lsb_c !== 1'b0) begin errors++; $display("FAIL reset_lsb_c: got %0h want 0", lsb_c); end
        checks++; if (lsb_h !== 4'd0) begin errors++; $display("FAIL reset_lsb_h: got %0h want 0", lsb_h); end
        checks++; if (f_rst !== 1'b0) begin errors++; $display("FAIL reset_f_rst: got %0h want 0", f_rst); end
        checks++; if (f_pc !== 32'd0) begin errors++; $display("FAIL reset_f_pc: got %0h want 0", f_pc); end
        checks++; if (tag !== 4'd1) begin errors++; $display("FAIL reset_tag: got %0h want 1", tag); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h want 0", full); end
    endtask

    task automatic test_basic_commit();
        do_reset();
        checks++; if (tag !== 4'd1) begin errors++; $display("FAIL basic_tag: got %0h want 1", tag); end
        alloc(2'd0, 5'd5);
        bcast(4'd1, 32'h1234, 1'b0, 32'h0);
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL basic_early: got %0h want 0", rf_en); end
        cyc();
        checks++; if (rf_en !== 1'b1) begin errors++; $display("FAIL basic_en: got %0h want 1", rf_en); end
        checks++; if (rf_d !== 5'd5) begin errors++; $display("FAIL basic_d: got %0h want 5", rf_d); end
        checks++; if (rf_val !== 32'h1234) begin errors++; $display("FAIL basic_val: got %0h want 1234", rf_val); end
        checks++; if (rf_h !== 4'd1) begin errors++; $display("FAIL basic_h: got %0h want 1", rf_h); end
        cyc();
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL basic_once: got %0h want 0", rf_en); end
        checks++; if (tag !== 4'd2) begin errors++; $display("FAIL basic_next_tag: got %0h want 2", tag); end
    endtask

    task automatic test_full_wrap();
        logic [3:0] want;
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            want = 4'(i);
            en = 1; typ = 2'd0; dest = 5'(i);
            #1;
            checks++; if (tag !== want) begin errors++; $display("FAIL wrap_tag%0d: got %0h want %0h", i, tag, want); end
            cyc();
        end
        en = 0; #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %0h want 1", full); end
        alloc(2'd0, 5'd20);
        bcast(4'd1, 32'h55, 1'b0, 32'h0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_still_full: got %0h want 1", full); end
        cyc();
        checks++; if (rf_h !== 4'd1) begin errors++; $display("FAIL wrap_commit_h: got %0h want 1", rf_h); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_not_full: got %0h want 0", full); end
        checks++; if (tag !== 4'd1) begin errors++; $display("FAIL wrap_tag_reuse: got %0h want 1", tag); end
        alloc(2'd0, 5'd9);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_refull: got %0h want 1", full); end
        checks++; if (tag !== 4'd2) begin errors++; $display("FAIL wrap_tag_after: got %0h want 2", tag); end
    endtask

    task automatic test_in_order();
        do_reset();
        alloc(2'd0, 5'd3);
        alloc(2'd0, 5'd4);
        bcast(4'd2, 32'd22, 1'b0, 32'h0);
        cyc();
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL order_wait1: got %0h want 0", rf_en); end
        cyc();
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL order_wait2: got %0h want 0", rf_en); end
        bcast(4'd1, 32'd11, 1'b0, 32'h0);
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL order_wait3: got %0h want 0", rf_en); end
        cyc();
        checks++; if (rf_en !== 1'b1 || rf_h !== 4'd1) begin errors++; $display("FAIL order_first: got en=%0h h=%0h want en=1 h=1", rf_en, rf_h); end
        checks++; if (rf_d !== 5'd3 || rf_val !== 32'd11) begin errors++; $display("FAIL order_first_data: got d=%0h v=%0h want d=3 v=b", rf_d, rf_val); end
        cyc();
        checks++; if (rf_en !== 1'b1 || rf_h !== 4'd2) begin errors++; $display("FAIL order_second: got en=%0h h=%0h want en=1 h=2", rf_en, rf_h); end
        checks++; if (rf_d !== 5'd4 || rf_val !== 32'd22) begin errors++; $display("FAIL order_second_data: got d=%0h v=%0h want d=4 v=16", rf_d, rf_val); end
        cyc();
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL order_done: got %0h want 0", rf_en); end
    endtask

    task automatic test_store();
        do_reset();
        alloc(2'd2, 5'd0);
        bcast(4'd1, 32'hAA, 1'b0, 32'h0);
        lsb_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (lsb_c !== 1'b0) begin errors++; $display("FAIL store_stall%0d: got %0h want 0", i, lsb_c); end
        end
        lsb_rdy = 1;
        cyc();
        lsb_rdy = 0;
        checks++; if (lsb_c !== 1'b1) begin errors++; $display("FAIL store_commit: got %0h want 1", lsb_c); end
        checks++; if (lsb_h !== 4'd1) begin errors++; $display("FAIL store_h: got %0h want 1", lsb_h); end
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL store_no_rf: got %0h want 0", rf_en); end
        cyc();
        checks++; if (lsb_c !== 1'b0) begin errors++; $display("FAIL store_pulse: got %0h want 0", lsb_c); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(2'd1, 5'd1);
        alloc(2'd0, 5'd2);
        alloc(2'd0, 5'd3);
        bcast(4'd2, 32'd5, 1'b0, 32'h0);
        bcast(4'd1, 32'h44, 1'b1, 32'h100);
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL mp_early: got %0h want 0", rf_en); end
        cyc();
        checks++; if (rf_en !== 1'b1 || rf_d !== 5'd1) begin errors++; $display("FAIL mp_link: got en=%0h d=%0h want en=1 d=1", rf_en, rf_d); end
        checks++; if (rf_val !== 32'h44) begin errors++; $display("FAIL mp_link_val: got %0h want 44", rf_val); end
        checks++; if (rf_rst !== 1'b0 || f_rst !== 1'b0) begin errors++; $display("FAIL mp_rst_early: got %0h/%0h want 0/0", rf_rst, f_rst); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL mp_full_in_flush: got %0h want 1", full); end
        en = 1; typ = 2'd0; dest = 5'd7;
        cyc();
        en = 0;
        checks++; if (rf_rst !== 1'b1 || f_rst !== 1'b1) begin errors++; $display("FAIL mp_rst: got %0h/%0h want 1/1", rf_rst, f_rst); end
        checks++; if (f_pc !== 32'h100) begin errors++; $display("FAIL mp_pc: got %0h want 100", f_pc); end
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL mp_no_write: got %0h want 0", rf_en); end
        checks++; if (full !== 1'b0 || tag !== 4'd1) begin errors++; $display("FAIL mp_after: got full=%0h tag=%0h want 0/1", full, tag); end
        cyc();
        checks++; if (rf_rst !== 1'b0 || f_rst !== 1'b0 || rf_en !== 1'b0) begin errors++; $display("FAIL mp_quiet: got %0h/%0h/%0h want 0/0/0", rf_rst, f_rst, rf_en); end
    endtask

    task automatic test_bypass();
        do_reset();
        alloc(2'd0, 5'd1);
        alloc(2'd0, 5'd2);
        alloc(2'd0, 5'd3);
        rs_h = 4'd3; rt_h = 4'd0; cdb_en = 1; cdb_h = 4'd3; cdb_val = 32'd7;
        #1;
        checks++; if (rs_rdy !== 1'b1 || rs_val !== 32'd7) begin errors++; $display("FAIL bypass_rs: got r=%0h v=%0h want 1/7", rs_rdy, rs_val); end
        checks++; if (rt_rdy !== 1'b0 || rt_val !== 32'd0) begin errors++; $display("FAIL bypass_tag0: got r=%0h v=%0h want 0/0", rt_rdy, rt_val); end
        rt_h = 4'd2; #1;
        checks++; if (rt_rdy !== 1'b0) begin errors++; $display("FAIL bypass_unready: got %0h want 0", rt_rdy); end
        cyc();
        cdb_en = 0; #1;
        checks++; if (rs_rdy !== 1'b1 || rs_val !== 32'd7) begin errors++; $display("FAIL bypass_stored: got r=%0h v=%0h want 1/7", rs_rdy, rs_val); end
        idle();
    endtask

    task automatic test_rdy_hold();
        do_reset();
        alloc(2'd0, 5'd6);
        bcast(4'd1, 32'h99, 1'b0, 32'h0);
        cyc();
        checks++; if (rf_en !== 1'b1) begin errors++; $display("FAIL hold_commit: got %0h want 1", rf_en); end
        rdy = 0; en = 1; typ = 2'd0; dest = 5'd7;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (rf_en !== 1'b1 || rf_d !== 5'd6) begin errors++; $display("FAIL hold_pulse%0d: got en=%0h d=%0h want 1/6", i, rf_en, rf_d); end
        end
        checks++; if (tag !== 4'd2) begin errors++; $display("FAIL hold_no_alloc: got %0h want 2", tag); end
        rdy = 1; en = 0;
        cyc();
        checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL hold_release: got %0h want 0", rf_en); end
    endtask

    task automatic test_random();
        int          cand[$];
        bit          er;
        logic [31:0] ev;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 249) == 0);
            rdy     = ($urandom_range(0, 7) != 0);
            en      = ($urandom_range(0, 2) != 0);
            typ     = 2'($urandom_range(0, 2));
            dest    = 5'($urandom_range(0, 31));
            lsb_rdy = $urandom_range(0, 1);
            rs_h    = 4'($urandom_range(0, 15));
            rt_h    = 4'($urandom_range(0, 15));
            cdb_en  = 0; cdb_mp = 0;
            cand.delete();
            foreach (q[i]) if (!q[i].rdy) cand.push_back(i);
            if (!m_flush && cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                int k;
                k       = cand[$urandom_range(0, cand.size() - 1)];
                cdb_en  = 1;
                cdb_h   = q[k].tag;
                cdb_val = $urandom;
                cdb_tgt = $urandom;
                cdb_mp  = (q[k].typ == 2'd1) && ($urandom_range(0, 3) == 0);
            end
            #1;
            checks++; if (full !== ((q.size() == 15) || m_flush)) begin errors++; $display("FAIL rnd_full@%0d: got %0h want %0h", c, full, (q.size() == 15) || m_flush); end
            checks++; if (tag !== m_next) begin errors++; $display("FAIL rnd_tag@%0d: got %0h want %0h", c, tag, m_next); end
            m_query(rs_h, er, ev);
            checks++; if (rs_rdy !== er || (er && rs_val !== ev)) begin errors++; $display("FAIL rnd_rs@%0d: got %0h/%0h want %0h/%0h", c, rs_rdy, rs_val, er, ev); end
            m_query(rt_h, er, ev);
            checks++; if (rt_rdy !== er || (er && rt_val !== ev)) begin errors++; $display("FAIL rnd_rt@%0d: got %0h/%0h want %0h/%0h", c, rt_rdy, rt_val, er, ev); end
            cyc();
            checks++; if ({rf_en, rf_d, rf_h} !== {e_rf_en, e_rf_d, e_rf_h}) begin errors++; $display("FAIL rnd_rf@%0d: got en=%0h d=%0h h=%0h want en=%0h d=%0h h=%0h", c, rf_en, rf_d, rf_h, e_rf_en, e_rf_d, e_rf_h); end
            checks++; if (rf_val !== e_rf_val) begin errors++; $display("FAIL rnd_rf_val@%0d: got %0h want %0h", c, rf_val, e_rf_val); end
            checks++; if ({lsb_c, lsb_h} !== {e_lsb_c, e_lsb_h}) begin errors++; $display("FAIL rnd_lsb@%0d: got %0h/%0h want %0h/%0h", c, lsb_c, lsb_h, e_lsb_c, e_lsb_h); end
            checks++; if ({rf_rst, f_rst, f_pc} !== {e_rf_rst, e_f_rst, e_f_pc}) begin errors++; $display("FAIL rnd_flush@%0d: got %0h/%0h/%0h want %0h/%0h/%0h", c, rf_rst, f_rst, f_pc, e_rf_rst, e_f_rst, e_f_pc); end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_in_order();
        test_store();
        test_mispredict();
        test_bypass();
        test_rdy_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
